// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and constants used by the MSHR pair allocator.
package vector_cache_pkg;

  localparam int MSHR_ENTRY_NUM = 16;
  localparam int MSHR_IDX_WIDTH = $clog2(MSHR_ENTRY_NUM);

  typedef logic [MSHR_IDX_WIDTH-1:0] mshr_idx_t;

  typedef enum logic {
    OFFER_IDLE = 1'b0,
    OFFER_HOLD = 1'b1
  } mshr_alloc_st_e;

endpackage

// File: rtl/cmn_lead_two.sv
// Finds the two lowest set bits of a vector; each result carries its own valid.
module cmn_lead_two #(
  parameter int WIDTH = 16,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_vld_1,
  output logic [IW-1:0]    o_idx_1,
  output logic             o_vld_2,
  output logic [IW-1:0]    o_idx_2
);

  always_comb begin
    o_vld_1 = 1'b0;
    o_idx_1 = '0;
    o_vld_2 = 1'b0;
    o_idx_2 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        if (!o_vld_1) begin
          o_vld_1 = 1'b1;
          o_idx_1 = IW'(i);
        end else if (!o_vld_2) begin
          o_vld_2 = 1'b1;
          o_idx_2 = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mshr_pair_alloc_ctrl.sv
// MSHR free-list manager offering two distinct free entries per handshake.
// Optional release checking is enabled by defining MSHR_PAIR_ALLOC_REL_CHK_EN.
module mshr_pair_alloc_ctrl
  import vector_cache_pkg::*;
#(
  parameter int ENTRY_NUM       = MSHR_ENTRY_NUM,
  parameter int ENTRY_IDX_WIDTH = $clog2(ENTRY_NUM),
  parameter int REL_NUM         = 2,
  localparam int CNT_W          = $clog2(ENTRY_NUM + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       mshr_alloc_vld,
  output logic [ENTRY_IDX_WIDTH-1:0] mshr_alloc_idx_1,
  output logic [ENTRY_IDX_WIDTH-1:0] mshr_alloc_idx_2,
  input  logic                       mshr_alloc_rdy,
  input  logic [REL_NUM-1:0]         v_rel_vld,
  input  logic [ENTRY_IDX_WIDTH-1:0] v_rel_idx [REL_NUM],
  output logic [ENTRY_NUM-1:0]       v_entry_busy,
  output logic [CNT_W-1:0]           free_cnt,
  output logic                       all_busy,
  output logic                       rel_err
);

  mshr_alloc_st_e             r_state;
  logic                       r_vld;
  logic                       r_init;
  logic [ENTRY_IDX_WIDTH-1:0] r_idx_1;
  logic [ENTRY_IDX_WIDTH-1:0] r_idx_2;
  logic [ENTRY_NUM-1:0]       r_busy;

  logic [ENTRY_NUM-1:0]       w_offered_mask;
  logic [ENTRY_NUM-1:0]       w_avail;
  logic [ENTRY_NUM-1:0]       w_rel_clr;
  logic [ENTRY_NUM-1:0]       w_busy_nxt;
  logic                       w_hs;
  logic                       w_cand_vld_1;
  logic                       w_cand_vld_2;
  logic [ENTRY_IDX_WIDTH-1:0] w_cand_idx_1;
  logic [ENTRY_IDX_WIDTH-1:0] w_cand_idx_2;
  logic [CNT_W-1:0]           w_free_cnt;

  // The pair currently on offer is excluded so the next pair is always distinct.
  always_comb begin
    w_offered_mask = '0;
    if (r_vld) begin
      w_offered_mask[r_idx_1] = 1'b1;
      w_offered_mask[r_idx_2] = 1'b1;
    end
  end

  assign w_avail = ~r_busy & ~w_offered_mask;
  assign w_hs    = r_vld & mshr_alloc_rdy;

  cmn_lead_two #(
    .WIDTH(ENTRY_NUM)
  ) u_lead_two (
    .i_vec  (w_avail),
    .o_vld_1(w_cand_vld_1),
    .o_idx_1(w_cand_idx_1),
    .o_vld_2(w_cand_vld_2),
    .o_idx_2(w_cand_idx_2)
  );

`ifdef MSHR_PAIR_ALLOC_REL_CHK_EN
  logic w_rel_bad;
  logic w_dup;
  logic r_rel_err;

  // Offered entries are never busy, so the busy test also catches them.
  always_comb begin
    w_rel_clr = '0;
    w_rel_bad = 1'b0;
    w_dup     = 1'b0;
    for (int p = 0; p < REL_NUM; p++) begin
      w_dup = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (v_rel_vld[q] && (v_rel_idx[q] == v_rel_idx[p])) w_dup = 1'b1;
      end
      if (v_rel_vld[p]) begin
        if (w_dup || !r_busy[v_rel_idx[p]]) w_rel_bad = 1'b1;
        else w_rel_clr[v_rel_idx[p]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_rel_err <= 1'b0;
    else if (w_rel_bad) r_rel_err <= 1'b1;
  end

  assign rel_err = r_rel_err;

  a_rel_legal: assert property (@(posedge clk) disable iff (!rst_n) !w_rel_bad);
`else
  always_comb begin
    w_rel_clr = '0;
    for (int p = 0; p < REL_NUM; p++) begin
      if (v_rel_vld[p]) w_rel_clr[v_rel_idx[p]] = 1'b1;
    end
  end

  assign rel_err = 1'b0;
`endif

  // Allocation is applied after release so a stray release cannot undo it.
  assign w_busy_nxt = (r_busy & ~w_rel_clr) | (w_hs ? w_offered_mask : '0);

  // r_init holds off the first offer by one cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= OFFER_IDLE;
      r_vld   <= 1'b0;
      r_init  <= 1'b0;
      r_idx_1 <= '0;
      r_idx_2 <= '0;
      r_busy  <= '0;
    end else begin
      r_init <= 1'b1;
      r_busy <= w_busy_nxt;
      case (r_state)
        OFFER_IDLE: begin
          if (r_init && w_cand_vld_1 && w_cand_vld_2) begin
            r_state <= OFFER_HOLD;
            r_vld   <= 1'b1;
            r_idx_1 <= w_cand_idx_1;
            r_idx_2 <= w_cand_idx_2;
          end
        end
        OFFER_HOLD: begin
          if (mshr_alloc_rdy) begin
            if (w_cand_vld_1 && w_cand_vld_2) begin
              r_idx_1 <= w_cand_idx_1;
              r_idx_2 <= w_cand_idx_2;
            end else begin
              r_state <= OFFER_IDLE;
              r_vld   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= OFFER_IDLE;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_free_cnt = w_free_cnt + {{(CNT_W-1){1'b0}}, ~r_busy[i]};
    end
  end

  assign mshr_alloc_vld   = r_vld;
  assign mshr_alloc_idx_1 = r_idx_1;
  assign mshr_alloc_idx_2 = r_idx_2;
  assign v_entry_busy     = r_busy;
  assign free_cnt         = w_free_cnt;
  assign all_busy         = &r_busy;

endmodule

// File: tb/tb_mshr_pair_alloc_ctrl.sv
// Scoreboarded bench for mshr_pair_alloc_ctrl; handshakes are checked against queued pairs.
module tb_mshr_pair_alloc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mshr_alloc_vld;
  logic [3:0]  mshr_alloc_idx_1;
  logic [3:0]  mshr_alloc_idx_2;
  logic        mshr_alloc_rdy;
  logic [1:0]  v_rel_vld;
  logic [3:0]  v_rel_idx [2];
  logic [15:0] v_entry_busy;
  logic [4:0]  free_cnt;
  logic        all_busy;
  logic        rel_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } pair_t;

  pair_t sbq[$];

`ifdef MSHR_PAIR_ALLOC_REL_CHK_EN
  localparam logic EXP_REL_ERR = 1'b1;
`else
  localparam logic EXP_REL_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  mshr_pair_alloc_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mshr_alloc_vld  (mshr_alloc_vld),
    .mshr_alloc_idx_1(mshr_alloc_idx_1),
    .mshr_alloc_idx_2(mshr_alloc_idx_2),
    .mshr_alloc_rdy  (mshr_alloc_rdy),
    .v_rel_vld       (v_rel_vld),
    .v_rel_idx       (v_rel_idx),
    .v_entry_busy    (v_entry_busy),
    .free_cnt        (free_cnt),
    .all_busy        (all_busy),
    .rel_err         (rel_err)
  );

  // Every accepted pair must match the next expected pair in order.
  always @(negedge clk) begin : monitor
    pair_t exp_p;
    if (rst_n === 1'b1 && mshr_alloc_vld === 1'b1 && mshr_alloc_rdy === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL handshake_unexpected got (%0d,%0d) expected none",
                 mshr_alloc_idx_1, mshr_alloc_idx_2);
      end else begin
        exp_p = sbq.pop_front();
        if ({mshr_alloc_idx_1, mshr_alloc_idx_2} !== {exp_p.a, exp_p.b}) begin
          errors++;
          $display("[TB] FAIL handshake_pair got (%0d,%0d) expected (%0d,%0d)",
                   mshr_alloc_idx_1, mshr_alloc_idx_2, exp_p.a, exp_p.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    mshr_alloc_rdy = 1'b0;
    v_rel_vld      = 2'b00;
    v_rel_idx[0]   = 4'd0;
    v_rel_idx[1]   = 4'd0;
    sbq.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_alloc(input int npairs);
    do_reset();
    for (int k = 0; k < npairs; k++) sbq.push_back({4'(2*k), 4'(2*k+1)});
    mshr_alloc_rdy = 1'b1;
    tick();
    tick();
    repeat (npairs) tick();
    mshr_alloc_rdy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_offer got vld=%0b (%0d,%0d) expected 0 (0,0)",
               mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
    checks++;
    if ({v_entry_busy, free_cnt, all_busy, rel_err} !== {16'h0000, 5'd16, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state got busy=%h cnt=%0d all=%0b err=%0b expected 0000 16 0 0",
               v_entry_busy, free_cnt, all_busy, rel_err);
    end
  endtask

  task automatic test_fill();
    do_reset();
    mshr_alloc_rdy = 1'b1;
    for (int k = 0; k < 8; k++) sbq.push_back({4'(2*k), 4'(2*k+1)});
    tick();
    checks++;
    if (mshr_alloc_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_first_cycle got vld=%0b expected 0", mshr_alloc_vld);
    end
    tick();
    checks++;
    if ({mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2} !== {1'b1, 4'd0, 4'd1}) begin
      errors++;
      $display("[TB] FAIL fill_first_offer got vld=%0b (%0d,%0d) expected 1 (0,1)",
               mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
    repeat (8) tick();
    checks++;
    if ({mshr_alloc_vld, all_busy, free_cnt, v_entry_busy} !== {1'b0, 1'b1, 5'd0, 16'hFFFF}) begin
      errors++;
      $display("[TB] FAIL fill_end got vld=%0b all=%0b cnt=%0d busy=%h expected 0 1 0 ffff",
               mshr_alloc_vld, all_busy, free_cnt, v_entry_busy);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL fill_pending got %0d expected 0", sbq.size());
    end
    mshr_alloc_rdy = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2, v_entry_busy} !==
          {1'b1, 4'd0, 4'd1, 16'h0000}) begin
        errors++;
        $display("[TB] FAIL hold_stable cyc=%0d got vld=%0b (%0d,%0d) busy=%h expected 1 (0,1) 0000",
                 i, mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2, v_entry_busy);
      end
      tick();
    end
    sbq.push_back({4'd0, 4'd1});
    mshr_alloc_rdy = 1'b1;
    tick();
    mshr_alloc_rdy = 1'b0;
    checks++;
    if ({v_entry_busy, mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2} !==
        {16'h0003, 1'b1, 4'd2, 4'd3}) begin
      errors++;
      $display("[TB] FAIL hold_release got busy=%h vld=%0b (%0d,%0d) expected 0003 1 (2,3)",
               v_entry_busy, mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
  endtask

  task automatic test_release_refill();
    start_alloc(8);
    checks++;
    if (all_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rel_all_busy got %0b expected 1", all_busy);
    end
    v_rel_vld = 2'b01;
    v_rel_idx[0] = 4'd5;
    tick();
    v_rel_vld = 2'b00;
    tick();
    checks++;
    if ({free_cnt, mshr_alloc_vld, v_entry_busy} !== {5'd1, 1'b0, 16'hFFDF}) begin
      errors++;
      $display("[TB] FAIL rel_single got cnt=%0d vld=%0b busy=%h expected 1 0 ffdf",
               free_cnt, mshr_alloc_vld, v_entry_busy);
    end
    v_rel_vld = 2'b01;
    v_rel_idx[0] = 4'd9;
    tick();
    v_rel_vld = 2'b00;
    checks++;
    if ({free_cnt, mshr_alloc_vld} !== {5'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rel_second_edge got cnt=%0d vld=%0b expected 2 0", free_cnt, mshr_alloc_vld);
    end
    tick();
    checks++;
    if ({mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2} !== {1'b1, 4'd5, 4'd9}) begin
      errors++;
      $display("[TB] FAIL rel_pair got vld=%0b (%0d,%0d) expected 1 (5,9)",
               mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
    sbq.push_back({4'd5, 4'd9});
    mshr_alloc_rdy = 1'b1;
    tick();
    mshr_alloc_rdy = 1'b0;
    checks++;
    if ({v_entry_busy, mshr_alloc_vld} !== {16'hFFFF, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rel_refill got busy=%h vld=%0b expected ffff 0", v_entry_busy, mshr_alloc_vld);
    end
  endtask

  task automatic test_back_to_back();
    start_alloc(2);
    checks++;
    if ({v_entry_busy, mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2} !==
        {16'h000F, 1'b1, 4'd4, 4'd5}) begin
      errors++;
      $display("[TB] FAIL b2b_setup got busy=%h vld=%0b (%0d,%0d) expected 000f 1 (4,5)",
               v_entry_busy, mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
    sbq.push_back({4'd4, 4'd5});
    sbq.push_back({4'd6, 4'd7});
    sbq.push_back({4'd2, 4'd8});
    mshr_alloc_rdy = 1'b1;
    v_rel_vld = 2'b01;
    v_rel_idx[0] = 4'd2;
    tick();
    v_rel_vld = 2'b00;
    checks++;
    if ({v_entry_busy, mshr_alloc_idx_1, mshr_alloc_idx_2} !== {16'h003B, 4'd6, 4'd7}) begin
      errors++;
      $display("[TB] FAIL b2b_hs_rel got busy=%h (%0d,%0d) expected 003b (6,7)",
               v_entry_busy, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
    tick();
    checks++;
    if ({v_entry_busy, mshr_alloc_idx_1, mshr_alloc_idx_2} !== {16'h00FB, 4'd2, 4'd8}) begin
      errors++;
      $display("[TB] FAIL b2b_reoffer got busy=%h (%0d,%0d) expected 00fb (2,8)",
               v_entry_busy, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
    tick();
    mshr_alloc_rdy = 1'b0;
    checks++;
    if ({v_entry_busy, mshr_alloc_idx_1, mshr_alloc_idx_2, free_cnt} !==
        {16'h01FF, 4'd9, 4'd10, 5'd7}) begin
      errors++;
      $display("[TB] FAIL b2b_final got busy=%h (%0d,%0d) cnt=%0d expected 01ff (9,10) 7",
               v_entry_busy, mshr_alloc_idx_1, mshr_alloc_idx_2, free_cnt);
    end
  endtask

  task automatic test_reset_mid_handshake();
    start_alloc(1);
    rst_n = 1'b0;
    mshr_alloc_rdy = 1'b1;
    tick();
    checks++;
    if ({v_entry_busy, mshr_alloc_vld, free_cnt} !== {16'h0000, 1'b0, 5'd16}) begin
      errors++;
      $display("[TB] FAIL mid_reset got busy=%h vld=%0b cnt=%0d expected 0000 0 16",
               v_entry_busy, mshr_alloc_vld, free_cnt);
    end
    rst_n = 1'b1;
    mshr_alloc_rdy = 1'b0;
  endtask

  task automatic test_rel_check();
    do_reset();
    tick();
    tick();
    v_rel_vld = 2'b10;
    v_rel_idx[1] = 4'd7;
    tick();
    v_rel_vld = 2'b00;
    checks++;
    if ({v_entry_busy, rel_err, mshr_alloc_idx_1, mshr_alloc_idx_2} !==
        {16'h0000, EXP_REL_ERR, 4'd0, 4'd1}) begin
      errors++;
      $display("[TB] FAIL relchk_free got busy=%h err=%0b (%0d,%0d) expected 0000 %0b (0,1)",
               v_entry_busy, rel_err, mshr_alloc_idx_1, mshr_alloc_idx_2, EXP_REL_ERR);
    end
    v_rel_vld = 2'b01;
    v_rel_idx[0] = 4'd0;
    tick();
    v_rel_vld = 2'b00;
    checks++;
    if ({v_entry_busy, rel_err, mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2} !==
        {16'h0000, EXP_REL_ERR, 1'b1, 4'd0, 4'd1}) begin
      errors++;
      $display("[TB] FAIL relchk_offered got busy=%h err=%0b vld=%0b (%0d,%0d) expected 0000 %0b 1 (0,1)",
               v_entry_busy, rel_err, mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2, EXP_REL_ERR);
    end
    start_alloc(1);
    v_rel_vld = 2'b11;
    v_rel_idx[0] = 4'd1;
    v_rel_idx[1] = 4'd1;
    tick();
    v_rel_vld = 2'b00;
    checks++;
    if ({v_entry_busy, free_cnt, mshr_alloc_idx_1, mshr_alloc_idx_2} !==
        {16'h0001, 5'd15, 4'd2, 4'd3}) begin
      errors++;
      $display("[TB] FAIL relchk_dup got busy=%h cnt=%0d (%0d,%0d) expected 0001 15 (2,3)",
               v_entry_busy, free_cnt, mshr_alloc_idx_1, mshr_alloc_idx_2);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_release_refill();
    test_back_to_back();
    test_reset_mid_handshake();
    test_rel_check();
    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
